decode_stage_p: RTL
===================

Name: decode_stage_p

Overview:
- Parametrised decode stage for the pipelined ARM-subset core.
- Integrates instruction decode, a register file with write-through bypass, immediate extension and the D/E pipeline register.
- Adds three things over the previous generation: configurable data width and register count, a hold (StallE) control, and internal load-use hazard detection that inserts a bubble into E.
- Sits between the fetch/decode boundary and the execute stage.

Parameters:
- XLEN, 32, datapath width; must be >= 32. ExtImm is extended to XLEN.
- NREGS, 16, architectural register count; must be a power of two, >= 16. Index NREGS-1 is the PC.
- RAW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- InstD  in  32  instruction in D
- PCPlus8  in  XLEN  value returned on reads of the PC index
- InFlags  in  4  NZCV flags captured into FlagsE
- RegWriteW  in  1  writeback enable
- WA3W  in  RAW  writeback address
- ResultW  in  XLEN  writeback data
- FlushE  in  1  squash D/E contents (bubble)
- StallE  in  1  hold D/E contents
- RA1D, RA2D  out  RAW  decoded source addresses (to hazard unit)
- PCSrcD  out  1  combinational PC-write indication in D
- LdUseStall  out  1  combinational load-use hazard; upstream must stall F/D
- RD1E, RD2E, ExtImmE  out  XLEN  registered operands/immediate
- WA3E, RA1E, RA2E  out  RAW  registered addresses
- ValidE  out  1  E holds a real instruction
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE  out  1  registered controls
- ALUControlE  out  3  registered ALU operation
- FlagWriteE  out  2  registered flag-write enables
- CondE, FlagsE  out  4  registered condition field and flags

Behaviour:
- Instruction fields:
  - Opcode = InstD[27:26]; Funct = InstD[25:20]; cmd = Funct[4:1]; S = Funct[0].
  - Rd is InstD[15:12], zero-extended to RAW.
- Opcode 00, data processing:
  - ALUSrc = Funct[5]; ImmSrc = 00; RegSrc = 00.
  - cmd → ALUControl: ADD(0100)→000, SUB(0010)→001, AND(0000)→010, ORR(1100)→011, EOR(0001)→100, MOV(1101)→101, CMP(1010)→001.
  - RegWrite = 1, except CMP → 0.
  - FlagWrite[1] = S or CMP; FlagWrite[0] = (S or CMP) and cmd in {ADD, SUB, CMP}.
  - Any other cmd decodes as a NOP: all controls 0.
- Opcode 01, memory: ALUSrc = 1; ImmSrc = 01; ALUControl = 000.
  - LDR (S=1): RegWrite = 1, MemtoReg = 1, RegSrc = 00.
  - STR (S=0): MemWrite = 1, RegSrc = 10.
- Opcode 10, branch: Branch = 1, ALUSrc = 1, ImmSrc = 10, RegSrc = 01, ALUControl = 000.
- Opcode 11 decodes as a NOP.
- Source addresses:
  - RA1D = RegSrc[0] ? NREGS-1 : InstD[19:16].
  - RA2D = RegSrc[1] ? Rd : InstD[3:0].
- PCSrcD = Branch or (RegWrite and Rd == NREGS-1).
- Extend:
  - ImmSrc 00: zero-extend InstD[7:0].
  - ImmSrc 01: zero-extend InstD[11:0].
  - ImmSrc 10: sign-extend {InstD[23:0], 2'b00}.
- Register file:
  - NREGS-1 entries. Written on the rising clk edge when RegWriteW = 1 and WA3W != NREGS-1; PC-index writes are ignored.
  - Reads are combinational.
  - Reading the PC index returns PCPlus8.
  - If RegWriteW = 1, WA3W equals the read address, and that address is not the PC, the read returns ResultW in the same cycle (write-through bypass).
  - Reset clears all entries to 0.
- Load-use hazard: LdUseStall = ValidE & MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D)).
- D/E register update priority, evaluated at each rising edge:
  1. reset (asynchronous): all E outputs = 0, including ValidE = 0.
  2. FlushE: all E control outputs = 0, ValidE = 0. Data, address and flag fields take the D values.
  3. StallE: every E output holds. This applies even if LdUseStall = 1.
  4. LdUseStall: bubble, identical to FlushE.
  5. Otherwise: load all D values; ValidE = 1.
  - NOP decodes load with ValidE = 1 and controls 0.
- Latency:
  - One cycle from InstD to the E outputs.
  - Register-file write → visible on a D read in the same cycle via the bypass.
- Reset mid-operation: E is cleared immediately, without waiting for clk; the register file is cleared.

Test Plan:
- Reset, then decode ADD R1,R2,#5 (0xE2821005) with R2 = 0 → next cycle: ValidE = 1, ALUControlE = 000, ALUSrcE = 1, ExtImmE = 5, WA3E = 1, RegWriteE = 1, FlagWriteE = 00.
- Bypass: RegWriteW = 1, WA3W = 3, ResultW = 0xDEADBEEF, same cycle decode an instruction reading R3 → RD1E = 0xDEADBEEF next cycle. Then write WA3W = 15 and read R15 with PCPlus8 = 0x108 → reads 0x108; the write is ignored.
- Load-use: LDR R4,[R0] (0xE5904000) in E, ADD R5,R4,R4 in D → LdUseStall = 1; next cycle ValidE = 0 and controls 0. Then LdUseStall = 0 and the ADD enters E.
- Hold vs flush: StallE = 1 for 2 cycles → E outputs unchanged. Assert FlushE and StallE together → ValidE = 0 (flush wins).
- Branch B -2 (0xEAFFFFFE) → PCSrcD = 1; next cycle BranchE = 1, ExtImmE = 0xFFFFFFF8. MOV PC,R1 (0xE1A0F001) → PCSrcD = 1, RegWriteE = 1. CMP R1,R2 → RegWriteE = 0, FlagWriteE = 11.
- Assert reset asynchronously mid-cycle with E valid → ValidE and all E outputs drop to 0 before the next edge; R1 reads 0 afterwards. Repeat with XLEN = 64, NREGS = 32: sign-extended branch immediate is correct in 64 bits; PC index = 31.

Source files
------------

// File: rtl/decode_stage_p_if.sv
// D-stage boundary bundle: fetch/writeback/hazard inputs and the registered D/E outputs.
// The slave modport is the decode stage itself; master is whoever drives it.
interface decode_stage_p_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 16,
   parameter int RAW   = $clog2(NREGS)
);
   logic [31:0]     InstD;
   logic [XLEN-1:0] PCPlus8;
   logic [3:0]      InFlags;
   logic            RegWriteW;
   logic [RAW-1:0]  WA3W;
   logic [XLEN-1:0] ResultW;
   logic            FlushE;
   logic            StallE;

   logic [RAW-1:0]  RA1D, RA2D;
   logic            PCSrcD;
   logic            LdUseStall;

   logic [XLEN-1:0] RD1E, RD2E, ExtImmE;
   logic [RAW-1:0]  WA3E, RA1E, RA2E;
   logic            ValidE;
   logic            PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
   logic [2:0]      ALUControlE;
   logic [1:0]      FlagWriteE;
   logic [3:0]      CondE, FlagsE;

   modport master (
      output InstD, PCPlus8, InFlags, RegWriteW, WA3W, ResultW, FlushE, StallE,
      input  RA1D, RA2D, PCSrcD, LdUseStall,
      input  RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E, ValidE,
      input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
      input  ALUControlE, FlagWriteE, CondE, FlagsE
   );

   modport slave (
      input  InstD, PCPlus8, InFlags, RegWriteW, WA3W, ResultW, FlushE, StallE,
      output RA1D, RA2D, PCSrcD, LdUseStall,
      output RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E, ValidE,
      output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
      output ALUControlE, FlagWriteE, CondE, FlagsE
   );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage: instruction decode, bypassing register file, immediate extend,
// load-use bubble insertion and the D/E pipeline register.
module decode_stage_p #(
   parameter int XLEN  = 32,
   parameter int NREGS = 16,
   parameter int RAW   = $clog2(NREGS)
) (
   input logic            clk,
   input logic            reset,
   decode_stage_p_if.slave bus
);
   localparam logic [RAW-1:0] PC_IDX = RAW'(NREGS - 1);

   typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_NONE = 2'b11} op_e;
   localparam logic [3:0] C_AND = 4'b0000, C_EOR = 4'b0001, C_SUB = 4'b0010, C_ADD = 4'b0100,
                          C_CMP = 4'b1010, C_ORR = 4'b1100, C_MOV = 4'b1101;

   op_e             w_op;
   logic [5:0]      w_funct;
   logic [3:0]      w_cmd;
   logic            w_s, w_dp_ok;
   logic            w_regwrite, w_memtoreg, w_memwrite, w_branch, w_alusrc;
   logic [2:0]      w_aluctl;
   logic [1:0]      w_flagwrite, w_immsrc, w_regsrc;
   logic [RAW-1:0]  w_rd, w_ra1, w_ra2;
   logic [XLEN-1:0] w_extimm, w_rd1, w_rd2;
   logic            w_pcsrc, w_lduse, w_bubble, w_hold;

   logic [XLEN-1:0] r_rf [NREGS-1];
   logic [XLEN-1:0] r_rd1, r_rd2, r_extimm;
   logic [RAW-1:0]  r_wa3, r_ra1, r_ra2;
   logic            r_valid, r_pcsrc, r_regwrite, r_memtoreg, r_memwrite, r_branch, r_alusrc;
   logic [2:0]      r_aluctl;
   logic [1:0]      r_flagwrite;
   logic [3:0]      r_cond, r_flags;

   assign w_op    = op_e'(bus.InstD[27:26]);
   assign w_funct = bus.InstD[25:20];
   assign w_cmd   = w_funct[4:1];
   assign w_s     = w_funct[0];
   assign w_rd    = RAW'(bus.InstD[15:12]);

   always_comb begin
      w_dp_ok     = 1'b0;
      w_regwrite  = 1'b0;
      w_memtoreg  = 1'b0;
      w_memwrite  = 1'b0;
      w_branch    = 1'b0;
      w_alusrc    = 1'b0;
      w_aluctl    = '0;
      w_flagwrite = '0;
      w_immsrc    = '0;
      w_regsrc    = '0;
      case (w_op)
         OP_DP: begin
            w_dp_ok = 1'b1;
            case (w_cmd)
               C_ADD:   w_aluctl = 3'b000;
               C_SUB:   w_aluctl = 3'b001;
               C_AND:   w_aluctl = 3'b010;
               C_ORR:   w_aluctl = 3'b011;
               C_EOR:   w_aluctl = 3'b100;
               C_MOV:   w_aluctl = 3'b101;
               C_CMP:   w_aluctl = 3'b001;
               default: w_dp_ok  = 1'b0;
            endcase
            if (w_dp_ok) begin
               w_alusrc       = w_funct[5];
               w_regwrite     = (w_cmd != C_CMP);
               w_flagwrite[1] = w_s | (w_cmd == C_CMP);
               w_flagwrite[0] = w_flagwrite[1] &
                                ((w_cmd == C_ADD) | (w_cmd == C_SUB) | (w_cmd == C_CMP));
            end
         end
         OP_MEM: begin
            w_alusrc = 1'b1;
            w_immsrc = 2'b01;
            if (w_s) begin
               w_regwrite = 1'b1;
               w_memtoreg = 1'b1;
            end else begin
               w_memwrite = 1'b1;
               w_regsrc   = 2'b10;
            end
         end
         OP_BR: begin
            w_branch = 1'b1;
            w_alusrc = 1'b1;
            w_immsrc = 2'b10;
            w_regsrc = 2'b01;
         end
         default: ;
      endcase
   end

   assign w_ra1   = w_regsrc[0] ? PC_IDX : RAW'(bus.InstD[19:16]);
   assign w_ra2   = w_regsrc[1] ? w_rd : RAW'(bus.InstD[3:0]);
   assign w_pcsrc = w_branch | (w_regwrite & (w_rd == PC_IDX));

   always_comb begin
      case (w_immsrc)
         2'b01:   w_extimm = XLEN'(bus.InstD[11:0]);
         2'b10:   w_extimm = {{(XLEN-26){bus.InstD[23]}}, bus.InstD[23:0], 2'b00};
         default: w_extimm = XLEN'(bus.InstD[7:0]);
      endcase
   end

   // PC reads return PCPlus8; a same-cycle writeback to the read address wins over the array.
   always_comb begin
      if (w_ra1 == PC_IDX)                                 w_rd1 = bus.PCPlus8;
      else if (bus.RegWriteW && (bus.WA3W == w_ra1))       w_rd1 = bus.ResultW;
      else                                                 w_rd1 = r_rf[w_ra1];
      if (w_ra2 == PC_IDX)                                 w_rd2 = bus.PCPlus8;
      else if (bus.RegWriteW && (bus.WA3W == w_ra2))       w_rd2 = bus.ResultW;
      else                                                 w_rd2 = r_rf[w_ra2];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS - 1; i++) r_rf[i] <= '0;
      end else if (bus.RegWriteW && (bus.WA3W != PC_IDX)) begin
         r_rf[bus.WA3W] <= bus.ResultW;
      end
   end

   assign w_lduse = r_valid & r_memtoreg & r_regwrite & ((r_wa3 == w_ra1) | (r_wa3 == w_ra2));

   // Flush beats stall; a load-use bubble yields to stall so the held instruction survives.
   assign w_hold   = bus.StallE & ~bus.FlushE;
   assign w_bubble = bus.FlushE | (~bus.StallE & w_lduse);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd1 <= '0; r_rd2 <= '0; r_extimm <= '0;
         r_wa3 <= '0; r_ra1 <= '0; r_ra2 <= '0;
         r_cond <= '0; r_flags <= '0;
         r_valid <= 1'b0; r_pcsrc <= 1'b0; r_regwrite <= 1'b0; r_memtoreg <= 1'b0;
         r_memwrite <= 1'b0; r_branch <= 1'b0; r_alusrc <= 1'b0;
         r_aluctl <= '0; r_flagwrite <= '0;
      end else if (!w_hold) begin
         r_rd1 <= w_rd1; r_rd2 <= w_rd2; r_extimm <= w_extimm;
         r_wa3 <= w_rd; r_ra1 <= w_ra1; r_ra2 <= w_ra2;
         r_cond <= bus.InstD[31:28]; r_flags <= bus.InFlags;
         if (w_bubble) begin
            r_valid <= 1'b0; r_pcsrc <= 1'b0; r_regwrite <= 1'b0; r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0; r_branch <= 1'b0; r_alusrc <= 1'b0;
            r_aluctl <= '0; r_flagwrite <= '0;
         end else begin
            r_valid <= 1'b1; r_pcsrc <= w_pcsrc; r_regwrite <= w_regwrite;
            r_memtoreg <= w_memtoreg; r_memwrite <= w_memwrite; r_branch <= w_branch;
            r_alusrc <= w_alusrc; r_aluctl <= w_aluctl; r_flagwrite <= w_flagwrite;
         end
      end
   end

   assign bus.RA1D        = w_ra1;
   assign bus.RA2D        = w_ra2;
   assign bus.PCSrcD      = w_pcsrc;
   assign bus.LdUseStall  = w_lduse;
   assign bus.RD1E        = r_rd1;
   assign bus.RD2E        = r_rd2;
   assign bus.ExtImmE     = r_extimm;
   assign bus.WA3E        = r_wa3;
   assign bus.RA1E        = r_ra1;
   assign bus.RA2E        = r_ra2;
   assign bus.ValidE      = r_valid;
   assign bus.PCSrcE      = r_pcsrc;
   assign bus.RegWriteE   = r_regwrite;
   assign bus.MemtoRegE   = r_memtoreg;
   assign bus.MemWriteE   = r_memwrite;
   assign bus.BranchE     = r_branch;
   assign bus.ALUSrcE     = r_alusrc;
   assign bus.ALUControlE = r_aluctl;
   assign bus.FlagWriteE  = r_flagwrite;
   assign bus.CondE       = r_cond;
   assign bus.FlagsE      = r_flags;
endmodule
